// File: rtl/m_epp_host_pkg.sv
// Shared definitions for the EPP host: register map, status layout, FSM encoding.
package m_epp_host_pkg;

   localparam logic [1:0] ADR_DWR  = 2'd0;
   localparam logic [1:0] ADR_AWR  = 2'd1;
   localparam logic [1:0] ADR_DRD  = 2'd2;
   localparam logic [1:0] ADR_STAT = 2'd3;

   localparam int unsigned ST_BUSY    = 0;
   localparam int unsigned ST_RDVALID = 1;
   localparam int unsigned ST_TMO     = 2;
   localparam int unsigned ST_OVR     = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_RELEASE,
      S_RECOVER
   } state_t;

   typedef enum logic [1:0] {
      K_DW,
      K_AW,
      K_DR
   } kind_t;

   function automatic kind_t adr_to_kind(input logic [1:0] adr);
      kind_t k;
      k = K_DR;
      if (adr == ADR_DWR)
         k = K_DW;
      else if (adr == ADR_AWR)
         k = K_AW;
      return k;
   endfunction

   function automatic logic [7:0] status_byte(input logic busy, input logic rdvalid,
                                              input logic tmo, input logic ovr);
      logic [7:0] s;
      s             = '0;
      s[ST_BUSY]    = busy;
      s[ST_RDVALID] = rdvalid;
      s[ST_TMO]     = tmo;
      s[ST_OVR]     = ovr;
      return s;
   endfunction

endpackage

// File: rtl/m_sync2.sv
// Generic two-flop synchronizer with a configurable reset value.
module m_sync2 #(
   parameter int unsigned      W       = 1,
   parameter logic [W-1:0]     RST_VAL = '0
) (
   input  logic         CLK_I,
   input  logic         nADDRSTB,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge CLK_I or posedge nADDRSTB) begin
      if (nADDRSTB) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/m_epp_host.sv
// EPP initiator: turns midgetv register writes into address-write, data-write and
// data-read cycles on the parallel link, paced by the peripheral's nWAIT handshake.
module m_epp_host
   import m_epp_host_pkg::*;
#(
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic       nADDRSTB,
   input  logic       CLK_I,
   input  logic [7:0] DAT_I,
   input  logic [1:0] ADR_I,
   input  logic       STB_I,
   input  logic       WE_I,
   output logic [7:0] DAT_O,
   output logic       ACK_O,
   output logic       padnADDRSTB,
   output logic       padnDATASTB,
   output logic       padnWRITE,
   inout  logic [7:0] padDB,
   input  logic       padnWAIT
);

   state_t      state, state_n;
   kind_t       kind, kind_n;
   logic [7:0]  txreg, rxreg;
   logic        busy, rdvalid, tmo, ovr;
   logic [3:0]  scnt;
   logic [15:0] tcnt;
   logic        wait_s;
   logic [7:0]  db_s;
   logic        drive, drive_n;
   logic        astb_n, dstb_n;
   logic        wr_start, rd_stat, rd_data;
   logic        setup_done, tmo_at;
   logic        tcnt_clr, tcnt_inc, tmo_set, rx_load;

   m_sync2 #(.W(1), .RST_VAL(1'b0)) u_sync_wait (
      .CLK_I    (CLK_I),
      .nADDRSTB (nADDRSTB),
      .d        (padnWAIT),
      .q        (wait_s)
   );

   m_sync2 #(.W(8), .RST_VAL(8'h00)) u_sync_db (
      .CLK_I    (CLK_I),
      .nADDRSTB (nADDRSTB),
      .d        (padDB),
      .q        (db_s)
   );

   assign ACK_O      = STB_I;
   assign wr_start   = STB_I & WE_I & (ADR_I != ADR_STAT);
   assign rd_stat    = STB_I & ~WE_I & (ADR_I == ADR_STAT);
   assign rd_data    = STB_I & ~WE_I & (ADR_I == ADR_DWR);
   assign setup_done = (scnt >= 4'(SETUP_CYC - 1));
   assign tmo_at     = (tcnt == 16'(TIMEOUT - 1));

   assign DAT_O = (ADR_I == ADR_STAT) ? status_byte(busy, rdvalid, tmo, ovr) : rxreg;

   // The bus is released on the same edge that raises padnWRITE, so it is never driven with padnWRITE = 1.
   assign padDB = drive ? txreg : 'z;

   always_comb begin
      state_n  = state;
      kind_n   = kind;
      tcnt_clr = 1'b0;
      tcnt_inc = 1'b0;
      tmo_set  = 1'b0;
      rx_load  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (wr_start) begin
               state_n  = S_SETUP;
               kind_n   = adr_to_kind(ADR_I);
               tcnt_clr = 1'b1;
            end
         end
         S_SETUP: begin
            if (setup_done) begin
               if (!wait_s) begin
                  state_n  = S_STROBE;
                  tcnt_clr = 1'b1;
               end else if (tmo_at) begin
                  state_n = S_IDLE;
                  tmo_set = 1'b1;
               end else begin
                  tcnt_inc = 1'b1;
               end
            end
         end
         S_STROBE: begin
            if (wait_s) begin
               state_n = S_RELEASE;
            end else if (tmo_at) begin
               state_n = S_IDLE;
               tmo_set = 1'b1;
            end else begin
               tcnt_inc = 1'b1;
            end
         end
         S_RELEASE: begin
            state_n  = S_RECOVER;
            tcnt_clr = 1'b1;
            rx_load  = (kind == K_DR);
         end
         S_RECOVER: begin
            if (!wait_s) begin
               state_n = S_IDLE;
            end else if (tmo_at) begin
               state_n = S_IDLE;
               tmo_set = 1'b1;
            end else begin
               tcnt_inc = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
      // Pad controls are decoded from the next state so they leave the flops glitch-free.
      drive_n = (kind_n != K_DR) &&
                ((state_n == S_SETUP) || (state_n == S_STROBE) || (state_n == S_RELEASE));
      astb_n  = !((state_n == S_STROBE) && (kind_n == K_AW));
      dstb_n  = !((state_n == S_STROBE) && (kind_n != K_AW));
   end

   always_ff @(posedge CLK_I or posedge nADDRSTB) begin
      if (nADDRSTB) begin
         state       <= S_IDLE;
         kind        <= K_DW;
         txreg       <= '0;
         rxreg       <= '0;
         busy        <= 1'b0;
         rdvalid     <= 1'b0;
         tmo         <= 1'b0;
         ovr         <= 1'b0;
         scnt        <= '0;
         tcnt        <= '0;
         drive       <= 1'b0;
         padnWRITE   <= 1'b1;
         padnADDRSTB <= 1'b1;
         padnDATASTB <= 1'b1;
      end else begin
         state       <= state_n;
         kind        <= kind_n;
         busy        <= (state_n != S_IDLE);
         drive       <= drive_n;
         padnWRITE   <= !drive_n;
         padnADDRSTB <= astb_n;
         padnDATASTB <= dstb_n;

         if ((state == S_IDLE) && wr_start && (ADR_I != ADR_DRD))
            txreg <= DAT_I;

         if (state == S_IDLE)
            scnt <= '0;
         else if ((state == S_SETUP) && !setup_done)
            scnt <= scnt + 4'd1;

         if (tcnt_clr)
            tcnt <= '0;
         else if (tcnt_inc)
            tcnt <= tcnt + 16'd1;

         if (rx_load)
            rxreg <= db_s;

         // Setting events take priority over the clear-on-read side effects.
         if (rx_load)
            rdvalid <= 1'b1;
         else if (rd_data)
            rdvalid <= 1'b0;

         if (tmo_set)
            tmo <= 1'b1;
         else if (rd_stat)
            tmo <= 1'b0;

         if (wr_start && busy)
            ovr <= 1'b1;
         else if (rd_stat)
            ovr <= 1'b0;
      end
   end

endmodule

// File: tb/tb_m_epp_host.sv
// Self-checking bench for m_epp_host with a behavioural EPP peripheral and register model.
module tb_m_epp_host;

   localparam int unsigned SETUP_CYC = 3;
   localparam int unsigned TIMEOUT   = 16;

   logic       CLK_I    = 1'b0;
   logic       nADDRSTB = 1'b1;
   logic [7:0] DAT_I    = '0;
   logic [1:0] ADR_I    = '0;
   logic       STB_I    = 1'b0;
   logic       WE_I     = 1'b0;
   logic [7:0] DAT_O;
   logic       ACK_O;
   logic       padnADDRSTB, padnDATASTB, padnWRITE;
   tri1  [7:0] padDB;
   logic       padnWAIT = 1'b0;

   logic       per_oe = 1'b0;
   logic [7:0] per_db = '0;
   assign padDB = per_oe ? per_db : 8'hzz;

   int n_checks = 0;
   int n_fail   = 0;

   // peripheral model state
   int         resp_delay  = 3;
   bit         per_stuck   = 1'b0;
   logic [7:0] per_rd_val  = '0;
   logic [7:0] per_reg     = '0;
   int         per_done    = 0;
   int         per_kind    = -1;
   logic [7:0] per_data    = '0;
   int         pulses_a    = 0;
   int         pulses_d    = 0;
   int         strobe_low  = 0;
   int         setup_seen  = 0;

   // register-level expectation of the host
   bit         m_ovr = 1'b0, m_tmo = 1'b0, m_rdv = 1'b0;
   logic [7:0] m_rx  = '0;

   bit mon_en   = 1'b0;
   int mon_viol = 0;

   m_epp_host #(.SETUP_CYC(SETUP_CYC), .TIMEOUT(TIMEOUT)) dut (
      .nADDRSTB    (nADDRSTB),
      .CLK_I       (CLK_I),
      .DAT_I       (DAT_I),
      .ADR_I       (ADR_I),
      .STB_I       (STB_I),
      .WE_I        (WE_I),
      .DAT_O       (DAT_O),
      .ACK_O       (ACK_O),
      .padnADDRSTB (padnADDRSTB),
      .padnDATASTB (padnDATASTB),
      .padnWRITE   (padnWRITE),
      .padDB       (padDB),
      .padnWAIT    (padnWAIT)
   );

   always #5 CLK_I = ~CLK_I;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running required finished");
      $fatal(1);
   end

   // EPP peripheral: answers a strobe after resp_delay cycles, releases nWAIT once the strobe rises.
   initial begin : peripheral
      bit         active;
      bit         strb;
      int         cnt;
      int         setup_run;
      logic [7:0] last_db;
      active    = 1'b0;
      cnt       = 0;
      setup_run = 0;
      last_db   = 8'hFF;
      forever begin
         @(negedge CLK_I);
         strb = !padnADDRSTB || !padnDATASTB;
         if (!active) begin
            if (strb) begin
               active     = 1'b1;
               cnt        = 0;
               strobe_low = 0;
               setup_seen = setup_run;
               if (!padnADDRSTB) pulses_a++;
               if (!padnDATASTB) pulses_d++;
            end else begin
               if (!padnWRITE) setup_run = (padDB == last_db) ? setup_run + 1 : 1;
               else            setup_run = 0;
               last_db = padDB;
            end
         end
         if (active) begin
            if (strb) begin
               strobe_low++;
               if (!padnWAIT && !per_stuck) begin
                  if (cnt >= resp_delay) begin
                     if (!padnWRITE) begin
                        per_kind = padnADDRSTB ? 0 : 1;
                        per_data = padDB;
                        if (padnADDRSTB) per_reg = padDB;
                     end else begin
                        per_kind = 2;
                        per_data = per_rd_val;
                        per_db   = per_rd_val;
                        per_oe   = 1'b1;
                     end
                     padnWAIT = 1'b1;
                  end else begin
                     cnt++;
                  end
               end
            end else begin
               per_oe   = 1'b0;
               padnWAIT = 1'b0;
               active   = 1'b0;
               per_done++;
            end
         end
      end
   end

   // Link invariants: never two strobes low; host never drives while padnWRITE = 1.
   always begin
      @(posedge CLK_I);
      #2;
      if (mon_en) begin
         if (!padnADDRSTB && !padnDATASTB) mon_viol++;
         if (padnWRITE && !per_oe && (padDB !== 8'hFF)) mon_viol++;
      end
   end

   function automatic logic [7:0] exp_status(input bit busy);
      return {4'b0, m_ovr, m_tmo, m_rdv, busy};
   endfunction

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge CLK_I);
      STB_I = 1'b1; WE_I = 1'b1; ADR_I = a; DAT_I = d;
      #1;
      n_checks++;
      if (ACK_O !== 1'b1) begin
         n_fail++;
         $display("FAIL ack_write: ACK_O=%b required 1", ACK_O);
      end
      @(posedge CLK_I);
      #1;
      STB_I = 1'b0; WE_I = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
      @(negedge CLK_I);
      STB_I = 1'b1; WE_I = 1'b0; ADR_I = a;
      #1;
      d = DAT_O;
      @(posedge CLK_I);
      #1;
      STB_I = 1'b0;
   endtask

   task automatic wait_done(input int prev, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK_I);
         if (per_done != prev) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (6) @(negedge CLK_I);
   endtask

   task automatic test_reset();
      logic [7:0] d;
      nADDRSTB = 1'b1;
      repeat (3) @(negedge CLK_I);
      n_checks++;
      if ({padnADDRSTB, padnDATASTB, padnWRITE} !== 3'b111) begin
         n_fail++;
         $display("FAIL reset_pads: strobes/nWRITE=%b required 111", {padnADDRSTB, padnDATASTB, padnWRITE});
      end
      n_checks++;
      if (padDB !== 8'hFF) begin
         n_fail++;
         $display("FAIL reset_bus: padDB=%h required released (ff)", padDB);
      end
      nADDRSTB = 1'b0;
      mon_en   = 1'b1;
      bus_read(2'd3, d);
      n_checks++;
      if (d !== exp_status(1'b0)) begin
         n_fail++;
         $display("FAIL reset_status: got %h required %h", d, exp_status(1'b0));
      end
      bus_read(2'd1, d);
      n_checks++;
      if (d !== m_rx) begin
         n_fail++;
         $display("FAIL reset_rxreg: got %h required %h", d, m_rx);
      end
   endtask

   task automatic test_data_write();
      logic [7:0] d;
      int prev, pd;
      bit ok;
      resp_delay = 3;
      prev = per_done;
      pd   = pulses_d;
      bus_write(2'd0, 8'hA5);
      bus_read(2'd3, d);
      n_checks++;
      if (d !== exp_status(1'b1)) begin
         n_fail++;
         $display("FAIL dw_busy: status %h required %h", d, exp_status(1'b1));
      end
      wait_done(prev, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL dw_handshake: completed=0 required 1");
      end
      n_checks++;
      if (per_kind != 0 || per_data !== 8'hA5 || pulses_d != pd + 1) begin
         n_fail++;
         $display("FAIL dw_cycle: kind=%0d data=%h pulses=%0d required kind=0 data=a5 pulses=%0d",
                  per_kind, per_data, pulses_d - pd, 1);
      end
      n_checks++;
      if (setup_seen < SETUP_CYC) begin
         n_fail++;
         $display("FAIL dw_setup: stable cycles=%0d required >=%0d", setup_seen, SETUP_CYC);
      end
      bus_read(2'd3, d);
      n_checks++;
      if (d !== exp_status(1'b0)) begin
         n_fail++;
         $display("FAIL dw_status: got %h required %h", d, exp_status(1'b0));
      end
   endtask

   task automatic test_addr_then_read();
      logic [7:0] d;
      int prev, pa, pd;
      bit ok;
      resp_delay = 2;
      prev = per_done;
      pa = pulses_a;
      pd = pulses_d;
      bus_write(2'd1, 8'h01);
      wait_done(prev, ok);
      n_checks++;
      if (!ok || per_kind != 1 || per_data !== 8'h01 || pulses_a != pa + 1 || pulses_d != pd) begin
         n_fail++;
         $display("FAIL aw_cycle: ok=%0b kind=%0d data=%h apulses=%0d dpulses=%0d required 1 1 01 1 0",
                  ok, per_kind, per_data, pulses_a - pa, pulses_d - pd);
      end
      per_rd_val = 8'h3C;
      prev = per_done;
      bus_write(2'd2, 8'hFF);
      wait_done(prev, ok);
      m_rx  = 8'h3C;
      m_rdv = 1'b1;
      n_checks++;
      if (!ok || per_kind != 2 || pulses_d != pd + 1 || pulses_a != pa + 1) begin
         n_fail++;
         $display("FAIL dr_cycle: ok=%0b kind=%0d dpulses=%0d apulses=%0d required 1 2 1 1",
                  ok, per_kind, pulses_d - pd, pulses_a - pa);
      end
      bus_read(2'd3, d);
      n_checks++;
      if (d !== exp_status(1'b0)) begin
         n_fail++;
         $display("FAIL dr_status: got %h required %h", d, exp_status(1'b0));
      end
      bus_read(2'd0, d);
      m_rdv = 1'b0;
      n_checks++;
      if (d !== 8'h3C) begin
         n_fail++;
         $display("FAIL dr_data: got %h required 3c", d);
      end
      bus_read(2'd3, d);
      n_checks++;
      if (d !== exp_status(1'b0)) begin
         n_fail++;
         $display("FAIL dr_status_clear: got %h required %h", d, exp_status(1'b0));
      end
   endtask

   task automatic test_timeout();
      logic [7:0] d;
      int prev;
      bit ok;
      per_stuck = 1'b1;
      prev = per_done;
      bus_write(2'd2, 8'h00);
      wait_done(prev, ok);
      per_stuck = 1'b0;
      m_tmo = 1'b1;
      n_checks++;
      if (!ok || strobe_low != TIMEOUT) begin
         n_fail++;
         $display("FAIL tmo_strobe_len: ok=%0b strobe low cycles=%0d required %0d", ok, strobe_low, TIMEOUT);
      end
      bus_read(2'd3, d);
      n_checks++;
      if (d !== exp_status(1'b0)) begin
         n_fail++;
         $display("FAIL tmo_status: got %h required %h", d, exp_status(1'b0));
      end
      m_tmo = 1'b0;
      bus_read(2'd3, d);
      n_checks++;
      if (d !== exp_status(1'b0)) begin
         n_fail++;
         $display("FAIL tmo_status_clear: got %h required %h", d, exp_status(1'b0));
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      int prev;
      bit ok;
      resp_delay = 2;
      prev = per_done;
      bus_write(2'd0, 8'h11);
      bus_write(2'd0, 8'h22);
      m_ovr = 1'b1;
      wait_done(prev, ok);
      repeat (20) @(negedge CLK_I);
      n_checks++;
      if (!ok || per_done != prev + 1 || per_kind != 0 || per_data !== 8'h11) begin
         n_fail++;
         $display("FAIL ovr_cycles: transactions=%0d kind=%0d data=%h required 1 0 11",
                  per_done - prev, per_kind, per_data);
      end
      bus_read(2'd3, d);
      n_checks++;
      if (d !== exp_status(1'b0)) begin
         n_fail++;
         $display("FAIL ovr_status: got %h required %h", d, exp_status(1'b0));
      end
      m_ovr = 1'b0;
      bus_read(2'd3, d);
      n_checks++;
      if (d !== exp_status(1'b0)) begin
         n_fail++;
         $display("FAIL ovr_status_clear: got %h required %h", d, exp_status(1'b0));
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      bit seen;
      resp_delay = 10;
      bus_write(2'd0, 8'h5A);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK_I);
         if (!padnDATASTB) begin
            seen = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL rst_mid_strobe: data strobe seen=0 required 1");
      end
      #2;
      nADDRSTB = 1'b1;
      #1;
      n_checks++;
      if ({padnADDRSTB, padnDATASTB, padnWRITE} !== 3'b111 || padDB !== 8'hFF) begin
         n_fail++;
         $display("FAIL rst_mid_pads: strobes/nWRITE=%b bus=%h required 111 ff",
                  {padnADDRSTB, padnDATASTB, padnWRITE}, padDB);
      end
      @(negedge CLK_I);
      nADDRSTB = 1'b0;
      {m_ovr, m_tmo, m_rdv} = 3'b000;
      m_rx = 8'h00;
      resp_delay = 3;
      repeat (4) @(negedge CLK_I);
      bus_read(2'd3, d);
      n_checks++;
      if (d !== exp_status(1'b0)) begin
         n_fail++;
         $display("FAIL rst_mid_status: got %h required %h", d, exp_status(1'b0));
      end
   endtask

   task automatic test_loopback();
      logic [7:0] d;
      int prev;
      bit ok;
      resp_delay = 1;
      prev = per_done;
      bus_write(2'd0, 8'h55);
      wait_done(prev, ok);
      n_checks++;
      if (!ok || per_reg !== 8'h55) begin
         n_fail++;
         $display("FAIL loop_h2p: peripheral got %h required 55", per_reg);
      end
      per_rd_val = ~per_reg;
      prev = per_done;
      bus_write(2'd2, 8'h00);
      wait_done(prev, ok);
      m_rx  = 8'hAA;
      m_rdv = 1'b1;
      bus_read(2'd3, d);
      n_checks++;
      if (!ok || d !== exp_status(1'b0)) begin
         n_fail++;
         $display("FAIL loop_status: got %h required %h", d, exp_status(1'b0));
      end
      bus_read(2'd0, d);
      m_rdv = 1'b0;
      n_checks++;
      if (d !== 8'hAA) begin
         n_fail++;
         $display("FAIL loop_p2h: host read %h required aa", d);
      end
   endtask

   task automatic test_random();
      logic [7:0] d, wd;
      int prev, op;
      bit ok;
      for (int it = 0; it < 24; it++) begin
         op         = int'($urandom_range(0, 3));
         wd         = 8'($urandom);
         resp_delay = int'($urandom_range(0, 5));
         per_rd_val = 8'($urandom);
         prev       = per_done;
         bus_write(2'(op), wd);
         if (op == 3) begin
            repeat (12) @(negedge CLK_I);
            n_checks++;
            if (per_done != prev) begin
               n_fail++;
               $display("FAIL rnd_ignored: transactions=%0d required 0", per_done - prev);
            end
         end else begin
            wait_done(prev, ok);
            if (op == 2) begin
               m_rx  = per_rd_val;
               m_rdv = 1'b1;
            end
            n_checks++;
            if (!ok || per_kind != (op == 0 ? 0 : op == 1 ? 1 : 2) ||
                (op != 2 && per_data !== wd)) begin
               n_fail++;
               $display("FAIL rnd_cycle: it=%0d op=%0d kind=%0d data=%h required data %h",
                        it, op, per_kind, per_data, wd);
            end
         end
         if ($urandom_range(0, 1) == 1) begin
            bus_read(2'd1, d);
            n_checks++;
            if (d !== m_rx) begin
               n_fail++;
               $display("FAIL rnd_rx_peek: got %h required %h", d, m_rx);
            end
         end
         bus_read(2'd3, d);
         n_checks++;
         if (d !== exp_status(1'b0)) begin
            n_fail++;
            $display("FAIL rnd_status: it=%0d got %h required %h", it, d, exp_status(1'b0));
         end
         if ($urandom_range(0, 2) == 0) begin
            bus_read(2'd0, d);
            m_rdv = 1'b0;
            n_checks++;
            if (d !== m_rx) begin
               n_fail++;
               $display("FAIL rnd_rx_pop: got %h required %h", d, m_rx);
            end
         end
      end
   endtask

   task automatic test_invariants();
      n_checks++;
      if (mon_viol != 0) begin
         n_fail++;
         $display("FAIL link_invariants: violations=%0d required 0", mon_viol);
      end
   endtask

   initial begin
      test_reset();
      test_data_write();
      test_addr_then_read();
      test_timeout();
      test_back_to_back();
      test_loopback();
      test_random();
      test_reset_mid();
      test_invariants();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
